// File: rtl/router_sync_n.sv
// N-channel router synchronizer: header address latch, one-hot FIFO write decode,
// full/valid steering and an optional per-channel stall watchdog (ROUTER_SYNC_WATCHDOG_EN).
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  // One extra bit so NUM_CH itself is representable when 2^ADDR_W == NUM_CH.
  localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W+1)'(NUM_CH);

  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_err;
  logic [ADDR_W-1:0] w_hdr_addr;
  logic              w_hdr_valid;
  logic              w_addr_valid;
  logic              w_unused_data;

  assign w_hdr_addr    = data_in[ADDR_W-1:0];
  assign w_hdr_valid   = {1'b0, w_hdr_addr} < NUM_CH_W;
  assign w_addr_valid  = {1'b0, r_addr} < NUM_CH_W;
  assign w_unused_data = ^data_in;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_addr     <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= detect_add & ~w_hdr_valid;
      if (detect_add)
        r_addr <= w_hdr_addr;
    end
  end

  assign addr_err = r_addr_err;

  // Invalid addresses match no channel, so the packet is dropped rather than stalled.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_addr_valid && (r_addr == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;

`ifdef ROUTER_SYNC_WATCHDOG_EN
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_soft_reset;
  logic [NUM_CH-1:0] w_stall;

  assign w_stall = vld_out & ~read_enb;

  // Counter clears on expiry, so a persistent stall re-pulses every TIMEOUT cycles.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++)
        r_cnt[i] <= '0;
      r_soft_reset <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_stall[i] && (r_cnt[i] == CNT_LAST)) begin
          r_cnt[i]        <= '0;
          r_soft_reset[i] <= 1'b1;
        end else if (w_stall[i]) begin
          r_cnt[i]        <= r_cnt[i] + CNT_W'(1);
          r_soft_reset[i] <= 1'b0;
        end else begin
          r_cnt[i]        <= '0;
          r_soft_reset[i] <= 1'b0;
        end
      end
    end
  end

  assign soft_reset = r_soft_reset;
`else
  logic w_unused_rd;

  assign w_unused_rd = ^read_enb;
  assign soft_reset  = '0;
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// Self-checking bench for router_sync_n: behavioural model compared every cycle
// plus directed literal checks from the test plan.
module tb_router_sync_n;
  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 30;
`ifdef ROUTER_SYNC_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              resetn;
  logic              detect_add;
  logic [DATA_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] full, empty, read_enb;
  logic [NUM_CH-1:0] write_enb, vld_out, soft_reset;
  logic              fifo_full, addr_err;

  int checks = 0;
  int errors = 0;

  router_sync_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .full(full), .empty(empty), .read_enb(read_enb),
    .write_enb(write_enb), .fifo_full(fifo_full), .vld_out(vld_out),
    .soft_reset(soft_reset), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  // Behavioural model: latched destination, error flag, per-channel stall run length.
  int              m_addr;
  bit              m_err;
  int              m_run [NUM_CH];
  bit [NUM_CH-1:0] m_sr;
  bit              m_started = 1'b0;

  always @(posedge clock) begin
    if (!resetn) begin
      m_addr = 0;
      m_err  = 1'b0;
      m_sr   = '0;
      for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
      m_started = 1'b1;
    end else begin
      m_err = detect_add && (int'(data_in % (1 << ADDR_W)) >= NUM_CH);
      if (detect_add) m_addr = int'(data_in % (1 << ADDR_W));
      for (int i = 0; i < NUM_CH; i++) begin
        m_sr[i] = 1'b0;
        if (!empty[i] && !read_enb[i]) begin
          m_run[i]++;
          if (m_run[i] == TIMEOUT) begin
            m_run[i] = 0;
            m_sr[i]  = WD_EN;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [NUM_CH-1:0] e_we;
    logic              e_ff;
    if (m_started) begin
      e_we = '0;
      e_ff = 1'b0;
      if (m_addr < NUM_CH) begin
        e_we[m_addr] = write_enb_reg;
        e_ff         = full[m_addr];
      end
      checks++;
      if (write_enb !== e_we || fifo_full !== e_ff || vld_out !== ~empty ||
          soft_reset !== m_sr || addr_err !== m_err) begin
        errors++;
        $display("FAIL model t=%0t we=%b/%b ff=%b/%b vld=%b/%b sr=%b/%b err=%b/%b (actual/required)",
                 $time, write_enb, e_we, fifo_full, e_ff, vld_out, ~empty, soft_reset, m_sr, addr_err, m_err);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    resetn = 1'b0; detect_add = 1'b0; data_in = '0; write_enb_reg = 1'b0;
    full = '0; empty = '1; read_enb = '0;
    step(2);
    resetn = 1'b1;
    write_enb_reg = 1'b1;
    #2;
    check("reset_sr", soft_reset, 0);
    check("reset_err", addr_err, 0);
    check("reset_addr0_we", write_enb, 3'b001);
    write_enb_reg = 1'b0;

    // Header to channel 2
    detect_add = 1'b1; data_in = 8'h06;
    step();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b100;
    #2;
    check("ch2_we", write_enb, 3'b100);
    check("ch2_full", fifo_full, 1);
    full = 3'b011;
    #1;
    check("ch2_notfull", fifo_full, 0);
    write_enb_reg = 1'b0;

    // Invalid address
    detect_add = 1'b1; data_in = 8'h03;
    step();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
    #2;
    check("bad_err_pulse", addr_err, 1);
    check("bad_we", write_enb, 0);
    check("bad_full", fifo_full, 0);
    step();
    check("bad_err_once", addr_err, 0);
    write_enb_reg = 1'b0; full = '0;

    // Same-cycle address change
    detect_add = 1'b1; data_in = 8'h00;
    step();
    data_in = 8'h01; write_enb_reg = 1'b1;
    #2;
    check("same_cyc_old", write_enb, 3'b001);
    step();
    detect_add = 1'b0;
    #2;
    check("same_cyc_new", write_enb, 3'b010);
    write_enb_reg = 1'b0;

    // Watchdog timeout on channel 1
    empty = 3'b101; read_enb = '0;
    #2;
    check("vld_out", vld_out, 3'b010);
    step(29);
    check("wd_before", soft_reset, 0);
    step();
    check("wd_pulse", soft_reset, WD_EN ? 3'b010 : 3'b000);
    step();
    check("wd_one_cycle", soft_reset, 0);

    // Read in cycle 29 suppresses the pulse
    empty = '1;
    step(2);
    empty = 3'b101;
    step(29);
    read_enb = 3'b010;
    step();
    read_enb = '0; empty = '1;
    #2;
    check("wd_read_supp", soft_reset, 0);
    step();
    check("wd_read_supp2", soft_reset, 0);

    // All channels stalling together
    empty = 3'b000;
    step(30);
    check("wd_all", soft_reset, WD_EN ? 3'b111 : 3'b000);
    empty = '1;
    step(2);

    // Reset during stall
    detect_add = 1'b1; data_in = 8'h02;
    step();
    detect_add = 1'b0; empty = 3'b101;
    step(20);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step(10);
    check("rst_stall_10", soft_reset, 0);
    step(19);
    check("rst_stall_29", soft_reset, 0);
    step();
    check("rst_stall_30", soft_reset, WD_EN ? 3'b010 : 3'b000);
    empty = '1; write_enb_reg = 1'b1;
    #2;
    check("rst_addr0", write_enb, 3'b001);
    write_enb_reg = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_sync_n.md
# router_sync_n

N-channel synchronizer for the router: the parametrised successor of the single-register enable-hold stage. It captures the destination address at each packet header and decodes the FSM write strobe to a one-hot per-channel FIFO write enable. It also returns the selected channel's full flag and drives per-channel `vld_out`. A per-channel stall watchdog issues a one-cycle `soft_reset` to any output FIFO whose data sits unread for `TIMEOUT` cycles. It sits between the router FSM, the N output FIFOs and the N output ports.

## Interface
Parameters:
- `NUM_CH`, default 3: number of output channels, 2..16.
- `ADDR_W`, default 2: width of the address field in `data_in[ADDR_W-1:0]`; must satisfy 2^ADDR_W >= NUM_CH.
- `DATA_W`, default 8: header/data byte width; must be >= ADDR_W.
- `TIMEOUT`, default 30: number of consecutive unread cycles before soft reset, 2..1023.

Ports:
- `clock`  in  1: clock, all state updates on the rising edge.
- `resetn`  in  1: reset `resetn`, synchronous, active-low.
- `detect_add`  in  1: header present on `data_in` this cycle; latch the address.
- `data_in`  in  DATA_W: header byte; the low ADDR_W bits hold the destination.
- `write_enb_reg`  in  1: FSM request to write the current byte.
- `full`  in  NUM_CH: per-FIFO full flags.
- `empty`  in  NUM_CH: per-FIFO empty flags.
- `read_enb`  in  NUM_CH: per-port read strobes.
- `write_enb`  out  NUM_CH: one-hot FIFO write enable.
- `fifo_full`  out  1: full flag of the currently addressed FIFO.
- `vld_out`  out  NUM_CH: per-port data-valid flag.
- `soft_reset`  out  NUM_CH: one-cycle per-FIFO flush pulse.
- `addr_err`  out  1: one-cycle pulse when the latched address is >= NUM_CH.

## Operation
Address register `addr` (ADDR_W bits):
- Loads `data_in[ADDR_W-1:0]` on any edge where `detect_add`=1.
- Holds its value otherwise.

Out-of-range address:
- `addr_valid` = (`addr` < NUM_CH).
- `addr_err` is registered. It is 1 for exactly the cycle after a load whose loaded value is >= NUM_CH, else 0.

Combinational outputs:
- `write_enb[i]` = `write_enb_reg` & `addr_valid` & (`addr` == i).
- `fifo_full` = `addr_valid` ? `full[addr]` : 0. An invalid-address packet is dropped, not stalled.
- `vld_out[i]` = ~`empty[i]`. No register, and no dependence on `resetn`.

Watchdog, one per channel i:
- Counter `cnt[i]` is ceil(log2(TIMEOUT)) bits.
- Stall cycle: `vld_out[i]`=1 and `read_enb[i]`=0.
- On a stall cycle with `cnt[i]` < TIMEOUT-1: `cnt[i]` increments and `soft_reset[i]` is 0 next cycle.
- On a stall cycle with `cnt[i]` == TIMEOUT-1: `cnt[i]` clears to 0 and `soft_reset[i]` is 1 next cycle.
- On any non-stall cycle: `cnt[i]` clears to 0 and `soft_reset[i]` is 0 next cycle.
- The counter never wraps or saturates. It always clears on expiry, so a continued stall pulses again after another TIMEOUT cycles.

## Timing
Reset values, on any edge with `resetn`=0, including mid-packet:
- `addr`=0, all `cnt`=0.
- `soft_reset`=0, `addr_err`=0.
- Reset takes priority over `detect_add`.

Address latency:
- A `detect_add` at edge k affects `write_enb` and `fifo_full` from cycle k+1.
- If `detect_add` and `write_enb_reg` are asserted in the same cycle, that cycle's `write_enb` uses the old `addr`.

Watchdog latency:
- With stall cycles c0..c(TIMEOUT-1), `soft_reset[i]` is high in cycle c(TIMEOUT) only.
- A `read_enb[i]` in any of c0..c(TIMEOUT-1) suppresses the pulse.

General:
- Channels are independent. Several `soft_reset` bits may pulse in the same cycle.
- `write_enb` is at most one-hot by construction.

## Configuration
Macro `ROUTER_SYNC_WATCHDOG_EN`:
- Defined: the watchdog counters and `soft_reset` logic are compiled in as described above.
- Undefined: no counters are built and `soft_reset` is tied to all zeros.
- Everything else behaves identically in both cases.

## Test plan
- Reset, then header on channel 2: with NUM_CH=3, `detect_add`=1 and `data_in`=8'h06. Next cycle, `write_enb_reg`=1 → `write_enb`=3'b100 and `fifo_full`=`full[2]`.
- Invalid address: with NUM_CH=3, header `data_in`=8'h03 → `addr_err`=1 for one cycle. Subsequent `write_enb_reg`=1 → `write_enb`=0 and `fifo_full`=0 even with `full`=3'b111.
- Same-cycle address change: `addr`=0, then `detect_add`=1 (data 8'h01) together with `write_enb_reg`=1 → `write_enb`=3'b001 that cycle and 3'b010 the next.
- Watchdog timeout: TIMEOUT=30, `empty[1]`=0 and `read_enb[1]`=0 for 30 cycles → `soft_reset`=3'b010 for exactly one cycle. With a read in cycle 29 instead → no pulse. With the macro undefined → `soft_reset` stays 0.
- Reset during stall: assert `resetn`=0 for one cycle after 20 stall cycles. Resume the stall → the pulse arrives 30 stall cycles after reset release, not 10; `addr` reads back as 0.
